trng_collector: RTL and testbench

- Consumer side of the TRNG ring-oscillator entropy path.
- Synchronises the asynchronous raw entropy bit and samples it at a programmable rate.
- Runs a repetition-count health test, applies von Neumann debiasing, and packs the surviving bits into WIDTH-bit words.
- Presents each word to the SoC bus/CSR logic through a one-deep valid/ready output buffer.

---
 rtl/trng_collector.sv | 202 ++++++++++++++++++++
 tb/tb_trng_collector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trng_collector.sv
// trng_collector: consumer side of the TRNG ring-oscillator entropy path.
// Synchronises raw_bit, samples it every div+1 cycles, runs a repetition-count
// health test, applies von Neumann debiasing and packs the surviving bits into
// WIDTH-bit words. Each word goes out through a one-deep valid/ready buffer.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   enable         collection enable; when low, all collection state is cleared
//   div            sample every div+1 clk cycles
//   raw_bit        asynchronous ring-oscillator entropy bit
//   data_o         output word (first collected bit in the MSB)
//   valid_o        data_o holds an unconsumed word
//   ready_i        consumer accepts data_o
//   overflow_o     sticky: a completed word was dropped
//   health_fail_o  sticky: repetition-count test tripped
//   clear_i        clears overflow_o, health_fail_o and the RCT count
module trng_collector #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned RCT_LIMIT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 raw_bit,
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overflow_o,
  output logic                 health_fail_o,
  input  logic                 clear_i
);

  localparam int unsigned BCW = $clog2(WIDTH);
  localparam int unsigned RCW = $clog2(RCT_LIMIT + 1);

  localparam logic [0:0] PAIR_EMPTY      = 1'b0;
  localparam logic [0:0] PAIR_HAVE_FIRST = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q,    sync_d;
  logic [DIV_WIDTH-1:0]   div_cnt_q, div_cnt_d;
  logic [DIV_WIDTH-1:0]   div_lim_q, div_lim_d;
  logic [0:0]             pair_q,    pair_d;
  logic                   first_q,   first_d;
  logic [WIDTH-1:0]       sh_q,      sh_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [RCW-1:0]         rct_cnt_q, rct_cnt_d;
  logic                   prev_q,    prev_d;
  logic [WIDTH-1:0]       data_q,    data_d;
  logic                   valid_q,   valid_d;
  logic                   ovf_q,     ovf_d;
  logic                   hf_q,      hf_d;

  logic           sample_c;
  logic           tick_c;
  logic [RCW-1:0] rct_inc_c;
  logic [RCW-1:0] rct_upd_c;
  logic           trip_c;
  logic           emit_c;
  logic           word_done_c;
  logic           ovf_set_c;

  // Next-state logic for the whole datapath and the pair-state FSM.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], raw_bit};
    div_cnt_d   = div_cnt_q;
    div_lim_d   = div_lim_q;
    pair_d      = pair_q;
    first_d     = first_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    rct_cnt_d   = rct_cnt_q;
    prev_d      = prev_q;
    data_d      = data_q;
    valid_d     = valid_q && !ready_i;
    ovf_d       = ovf_q;
    hf_d        = hf_q;
    emit_c      = 1'b0;
    word_done_c = 1'b0;

    sample_c = sync_q[SYNC_STAGES-1];
    tick_c   = enable && (div_cnt_q == div_lim_q);

    // Divider: the limit is only reloaded at a wrap (or while idle), so a
    // div change never truncates or stretches the period in progress.
    if (!enable) begin
      div_cnt_d = '0;
      div_lim_d = div;
    end else if (tick_c) begin
      div_cnt_d = '0;
      div_lim_d = div;
    end else begin
      div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
    end

    // Repetition count: a zero count always becomes 1 on the next tick,
    // whatever prev_q holds, so prev_q needs no clearing.
    rct_inc_c = (rct_cnt_q == RCW'(RCT_LIMIT)) ? rct_cnt_q : rct_cnt_q + RCW'(1);
    rct_upd_c = (sample_c == prev_q) ? rct_inc_c : RCW'(1);
    trip_c    = tick_c && (rct_upd_c == RCW'(RCT_LIMIT));

    if (tick_c) begin
      prev_d = sample_c;
    end
    if (!enable || clear_i) begin
      rct_cnt_d = '0;
    end else if (tick_c) begin
      rct_cnt_d = rct_upd_c;
    end

    // Von Neumann pairing; held empty while the health flag is up.
    if (!enable || hf_q) begin
      pair_d = PAIR_EMPTY;
    end else if (tick_c) begin
      case (pair_q)
        PAIR_EMPTY: begin
          pair_d  = PAIR_HAVE_FIRST;
          first_d = sample_c;
        end
        default: begin
          pair_d = PAIR_EMPTY;
          emit_c = (first_q != sample_c);
        end
      endcase
    end

    // Packing: the word completes on the same edge as its last bit.
    if (!enable) begin
      sh_d      = '0;
      bit_cnt_d = '0;
    end else if (emit_c) begin
      sh_d = {sh_q[WIDTH-2:0], first_q};
      if (bit_cnt_q == BCW'(WIDTH - 1)) begin
        bit_cnt_d   = '0;
        word_done_c = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BCW'(1);
      end
    end

    // Output buffer: a word loads if the slot is free or drains this cycle.
    ovf_set_c = word_done_c && valid_q && !ready_i;
    if (word_done_c && !ovf_set_c) begin
      data_d  = sh_d;
      valid_d = 1'b1;
    end

    // Sticky flags: a set in the same cycle beats clear_i.
    if (ovf_set_c) begin
      ovf_d = 1'b1;
    end else if (clear_i) begin
      ovf_d = 1'b0;
    end
    if (trip_c) begin
      hf_d = 1'b1;
    end else if (clear_i) begin
      hf_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      div_cnt_q <= '0;
      div_lim_q <= div;
      pair_q    <= PAIR_EMPTY;
      first_q   <= 1'b0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      rct_cnt_q <= '0;
      prev_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      hf_q      <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      div_cnt_q <= div_cnt_d;
      div_lim_q <= div_lim_d;
      pair_q    <= pair_d;
      first_q   <= first_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      rct_cnt_q <= rct_cnt_d;
      prev_q    <= prev_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      hf_q      <= hf_d;
    end
  end

  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign overflow_o    = ovf_q;
  assign health_fail_o = hf_q;

endmodule

// File: tb/tb_trng_collector.sv
// Bench for trng_collector (WIDTH=8): directed scenarios plus randomized
// traffic, every cycle compared against a sample/pair/word level model.
module tb_trng_collector;

  localparam int unsigned W     = 8;
  localparam int unsigned S     = 2;
  localparam int unsigned DW    = 8;
  localparam int unsigned LIMIT = 16;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [DW-1:0] div;
  logic          raw_bit;
  logic [W-1:0]  data_o;
  logic          valid_o;
  logic          ready_i;
  logic          overflow_o;
  logic          health_fail_o;
  logic          clear_i;

  trng_collector #(
    .WIDTH(W), .SYNC_STAGES(S), .DIV_WIDTH(DW), .RCT_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .div(div), .raw_bit(raw_bit),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .overflow_o(overflow_o), .health_fail_o(health_fail_o), .clear_i(clear_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int dut_ticks = 0;

  // Reference model state
  bit           m_hist[$];
  int           m_en_cyc;
  bit           m_prev;
  int           m_run;
  bit           m_pend;
  bit           m_first;
  bit           m_bits[$];
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_ovf;
  bit           m_hf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit s, tick, emit, eb, done, hf_set, ovf_set;
    int newrun;
    logic [W-1:0] word;
    word = '0;
    if (reset) begin
      m_hist.delete();
      for (int i = 0; i < int'(S); i++) m_hist.push_back(1'b0);
      m_en_cyc = 0; m_prev = 0; m_run = 0; m_pend = 0; m_first = 0;
      m_bits.delete(); m_data = '0; m_valid = 0; m_ovf = 0; m_hf = 0;
      return;
    end
    s = m_hist[S-1];
    m_hist.push_front(raw_bit);
    void'(m_hist.pop_back());

    tick = enable && (((m_en_cyc + 1) % (int'(div) + 1)) == 0);
    m_en_cyc = enable ? m_en_cyc + 1 : 0;

    hf_set = 0;
    if (!enable) m_run = 0;
    else if (tick) begin
      newrun = (s == m_prev) ? ((m_run + 1 > int'(LIMIT)) ? int'(LIMIT) : m_run + 1) : 1;
      hf_set = (newrun == int'(LIMIT));
      m_prev = s;
      m_run  = clear_i ? 0 : newrun;
    end else if (clear_i) m_run = 0;

    emit = 0; eb = 0;
    if (!enable || m_hf) m_pend = 0;
    else if (tick) begin
      if (!m_pend) begin
        m_pend = 1; m_first = s;
      end else begin
        m_pend = 0;
        if (m_first != s) begin emit = 1; eb = m_first; end
      end
    end

    done = 0;
    if (!enable) m_bits.delete();
    else if (emit) begin
      m_bits.push_back(eb);
      if (m_bits.size() == int'(W)) begin
        for (int i = 0; i < int'(W); i++) word[W-1-i] = m_bits[i];
        m_bits.delete();
        done = 1;
      end
    end

    ovf_set = done && m_valid && !ready_i;
    if (done && !ovf_set) begin
      m_data = word; m_valid = 1;
    end else if (m_valid && ready_i) m_valid = 0;
    m_ovf = ovf_set ? 1'b1 : (clear_i ? 1'b0 : m_ovf);
    m_hf  = hf_set  ? 1'b1 : (clear_i ? 1'b0 : m_hf);
  endtask

  // One clock: model update, edge, then compare all outputs.
  task automatic step();
    @(negedge clk);
    if (dut.tick_c) dut_ticks++;
    model_step();
    @(posedge clk);
    #1;
    chk("data_o", 32'(data_o), 32'(m_data));
    chk("valid_o", 32'(valid_o), 32'(m_valid));
    chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
    chk("health_fail_o", 32'(health_fail_o), 32'(m_hf));
  endtask

  // Preload the synchroniser with the pattern, then enable for nticks cycles
  // so that sample k of the enabled run is pattern element k (div=0).
  task automatic run_pat(input logic [7:0] pat, input int len, input int nticks, input logic rdy);
    enable = 1'b0; ready_i = rdy; clear_i = 1'b0; div = '0;
    raw_bit = pat[0]; step();
    raw_bit = pat[1 % len]; step();
    enable = 1'b1;
    for (int i = 0; i < nticks; i++) begin
      raw_bit = pat[(i + 2) % len];
      step();
    end
  endtask

  task automatic consume();
    enable = 1'b0; ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    chk("consumed_valid", 32'(valid_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int bias;
    logic r;
    reset = 1'b1; enable = 1'b0; div = '0; raw_bit = 1'b0; ready_i = 1'b0; clear_i = 1'b0;
    step(); step();
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_hf", 32'(health_fail_o), 32'd0);
    reset = 1'b0;

    // 10 -> 1 : 0xFF
    run_pat(8'h01, 2, 16, 1'b0);
    chk("p10_data", 32'(data_o), 32'hFF);
    chk("p10_valid", 32'(valid_o), 32'd1);
    chk("p10_ovf", 32'(overflow_o), 32'd0);
    consume();

    // 1001 -> 0xAA
    run_pat(8'h09, 4, 16, 1'b0);
    chk("p1001_data", 32'(data_o), 32'hAA);
    chk("p1001_valid", 32'(valid_o), 32'd1);
    consume();

    // 01 -> 0x00
    run_pat(8'h02, 2, 16, 1'b0);
    chk("p01_data", 32'(data_o), 32'h00);
    chk("p01_valid", 32'(valid_o), 32'd1);
    consume();

    // 1100 -> no word
    run_pat(8'h03, 4, 16, 1'b0);
    chk("p1100_valid", 32'(valid_o), 32'd0);

    // Health test: constant 1 trips on the 16th tick
    run_pat(8'h01, 1, 15, 1'b0);
    chk("rct15_hf", 32'(health_fail_o), 32'd0);
    raw_bit = 1'b1; step();
    chk("rct16_hf", 32'(health_fail_o), 32'd1);
    chk("rct16_valid", 32'(valid_o), 32'd0);
    raw_bit = 1'b0; step();
    raw_bit = 1'b1; step();
    raw_bit = 1'b0; clear_i = 1'b1; step();
    clear_i = 1'b0;
    chk("rct_clear_hf", 32'(health_fail_o), 32'd0);
    for (int i = 0; i < 18; i++) begin
      raw_bit = ~raw_bit; step();
    end
    chk("rct_resume_valid", 32'(valid_o), 32'd1);
    consume();

    // Overflow: second word dropped while first is held
    run_pat(8'h01, 2, 32, 1'b0);
    chk("ovf_data", 32'(data_o), 32'hFF);
    chk("ovf_valid", 32'(valid_o), 32'd1);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    consume();
    clear_i = 1'b1; step(); clear_i = 1'b0;
    chk("ovf_cleared", 32'(overflow_o), 32'd0);

    // div=3: 10 ticks in 40 enabled cycles
    enable = 1'b0; div = 8'd3; step();
    snap = dut_ticks;
    enable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      raw_bit = 1'($urandom_range(0, 1)); step();
    end
    chk("div3_ticks", 32'(dut_ticks - snap), 32'd10);

    // Enable dropped mid-word: partial bits discarded
    run_pat(8'h02, 2, 8, 1'b0);
    run_pat(8'h01, 2, 16, 1'b0);
    chk("reen_data", 32'(data_o), 32'hFF);
    chk("reen_valid", 32'(valid_o), 32'd1);
    consume();

    // Reset with a pending word and a partial word in progress
    run_pat(8'h01, 2, 16, 1'b0);
    run_pat(8'h01, 2, 6, 1'b0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("mrst_data", 32'(data_o), 32'd0);
    chk("mrst_valid", 32'(valid_o), 32'd0);
    chk("mrst_ovf", 32'(overflow_o), 32'd0);
    run_pat(8'h09, 4, 16, 1'b0);
    chk("mrst_word", 32'(data_o), 32'hAA);
    chk("mrst_word_valid", 32'(valid_o), 32'd1);
    consume();

    // Randomized traffic, alternating unbiased and heavily biased sources
    for (int seg = 0; seg < 6; seg++) begin
      enable = 1'b0; clear_i = 1'b0;
      div = DW'($urandom_range(0, 3));
      bias = (seg % 2 == 1) ? 90 : 50;
      step();
      for (int i = 0; i < 300; i++) begin
        r = ($urandom_range(0, 99) < bias);
        raw_bit = r;
        ready_i = ($urandom_range(0, 3) == 0);
        clear_i = ($urandom_range(0, 49) == 0);
        enable  = ($urandom_range(0, 99) != 0);
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
